// File: rtl/gerenciador_de_jogo_param_if.sv
// rtl/gerenciador_de_jogo_param_if.sv - game manager control/status bus (tiros_total present under CONTADOR_TIROS_EN)
interface gerenciador_de_jogo_param_if #(
    parameter int LINHAS  = 7,
    parameter int COLUNAS = 5,
    parameter int CW      = 3
);
    localparam int N = LINHAS * COLUNAS;

    logic [1:0]    modo;
    logic          confirmar;
    logic [CW-1:0] coord_linha;
    logic [CW-1:0] coord_coluna;
    logic [N-1:0]  mapa_in;
    logic [2:0]    estado;
    logic [N-1:0]  tiros_mat;
    logic [N-1:0]  acertos_mat;
    logic [2:0]    vida;
    logic          mapa_ok;
    logic          res_acerto;
    logic          res_erro;
    logic          res_repetido;
    logic          led_r;
    logic          led_g;
    logic          led_b;
`ifdef CONTADOR_TIROS_EN
    logic [5:0]    tiros_total;
`endif

    modport master (
        output modo, confirmar, coord_linha, coord_coluna, mapa_in,
        input  estado, tiros_mat, acertos_mat, vida, mapa_ok,
        input  res_acerto, res_erro, res_repetido, led_r, led_g, led_b
`ifdef CONTADOR_TIROS_EN
        , input tiros_total
`endif
    );

    modport slave (
        input  modo, confirmar, coord_linha, coord_coluna, mapa_in,
        output estado, tiros_mat, acertos_mat, vida, mapa_ok,
        output res_acerto, res_erro, res_repetido, led_r, led_g, led_b
`ifdef CONTADOR_TIROS_EN
        , output tiros_total
`endif
    );
endinterface

// File: rtl/gerenciador_de_jogo_param.sv
// rtl/gerenciador_de_jogo_param.sv - parametrised R x C attack game manager; CONTADOR_TIROS_EN adds shot counter
module gerenciador_de_jogo_param #(
    parameter int LINHAS  = 7,
    parameter int COLUNAS = 5,
    parameter int VIDAS   = 3,
    parameter int CW      = 3
) (
    input  logic clock_in,
    input  logic reset,
    gerenciador_de_jogo_param_if.slave bus
);
    localparam int N  = LINHAS * COLUNAS;
    localparam int NW = $clog2(N + 1);

    localparam logic [2:0] DESLIGADO  = 3'd0;
    localparam logic [2:0] PREPARACAO = 3'd1;
    localparam logic [2:0] ATAQUE     = 3'd2;
    localparam logic [2:0] VITORIA    = 3'd3;
    localparam logic [2:0] DERROTA    = 3'd4;

    logic [2:0]    estado;
    logic [N-1:0]  mapa;
    logic [N-1:0]  tiros;
    logic [N-1:0]  acertos;
    logic [NW-1:0] total_navios;
    logic [NW-1:0] acertos_cnt;
    logic [2:0]    vida;
    logic          mapa_ok;
    logic          res_acerto, res_erro, res_repetido;
    logic          led_r, led_g, led_b;
`ifdef CONTADOR_TIROS_EN
    logic [5:0]    tiros_total;
`endif

    logic [CW-1:0] lin, col;
    logic [NW-1:0] pop_mapa;
    logic          em_faixa;
    int            idx;
    logic [N-1:0]  celula;
    logic          ja_tirado, tem_navio, ir_desligar;

    assign lin = bus.coord_linha;
    assign col = bus.coord_coluna;

    always_comb begin
        pop_mapa = '0;
        for (int i = 0; i < N; i++) begin
            pop_mapa = pop_mapa + NW'(bus.mapa_in[i]);
        end
    end

    // One-hot mask of the target cell; empty when the coordinate lies off the board.
    always_comb begin
        em_faixa    = (int'(lin) < LINHAS) && (int'(col) < COLUNAS);
        idx         = int'(lin) * COLUNAS + int'(col);
        celula      = em_faixa ? (N'(1) << idx) : '0;
        ja_tirado   = |(tiros & celula);
        tem_navio   = |(mapa & celula);
        ir_desligar = (bus.modo == 2'b00) && (estado != DESLIGADO);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            estado       <= DESLIGADO;
            mapa         <= '0;
            tiros        <= '0;
            acertos      <= '0;
            total_navios <= '0;
            acertos_cnt  <= '0;
            vida         <= 3'(VIDAS);
            mapa_ok      <= 1'b0;
            res_acerto   <= 1'b0;
            res_erro     <= 1'b0;
            res_repetido <= 1'b0;
            {led_r, led_g, led_b} <= 3'b000;
`ifdef CONTADOR_TIROS_EN
            tiros_total  <= '0;
`endif
        end else begin
            res_acerto   <= 1'b0;
            res_erro     <= 1'b0;
            res_repetido <= 1'b0;
            if (ir_desligar) begin
                // The loaded map survives a return to DESLIGADO; the game itself does not.
                estado      <= DESLIGADO;
                tiros       <= '0;
                acertos     <= '0;
                acertos_cnt <= '0;
                vida        <= 3'(VIDAS);
                {led_r, led_g, led_b} <= 3'b000;
`ifdef CONTADOR_TIROS_EN
                tiros_total <= '0;
`endif
            end else begin
                case (estado)
                    DESLIGADO: begin
                        if (bus.modo == 2'b01) estado <= PREPARACAO;
                    end
                    PREPARACAO: begin
                        if (bus.confirmar && pop_mapa != '0) begin
                            mapa         <= bus.mapa_in;
                            total_navios <= pop_mapa;
                            mapa_ok      <= 1'b1;
                        end
                        if (bus.modo == 2'b10 && mapa_ok) estado <= ATAQUE;
                    end
                    ATAQUE: begin
                        if (bus.confirmar) begin
                            if (!em_faixa || ja_tirado) begin
                                res_repetido <= 1'b1;
                                {led_r, led_g, led_b} <= 3'b001;
                            end else begin
                                tiros <= tiros | celula;
`ifdef CONTADOR_TIROS_EN
                                if (tiros_total != 6'd63) tiros_total <= tiros_total + 6'd1;
`endif
                                if (tem_navio) begin
                                    acertos    <= acertos | celula;
                                    res_acerto <= 1'b1;
                                    {led_r, led_g, led_b} <= 3'b010;
                                    if (acertos_cnt != NW'(N)) acertos_cnt <= acertos_cnt + NW'(1);
                                    if (acertos_cnt + NW'(1) == total_navios) estado <= VITORIA;
                                end else begin
                                    res_erro <= 1'b1;
                                    {led_r, led_g, led_b} <= 3'b100;
                                    if (vida != 3'd0) vida <= vida - 3'd1;
                                    if (vida <= 3'd1) estado <= DERROTA;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.estado       = estado;
    assign bus.tiros_mat    = tiros;
    assign bus.acertos_mat  = acertos;
    assign bus.vida         = vida;
    assign bus.mapa_ok      = mapa_ok;
    assign bus.res_acerto   = res_acerto;
    assign bus.res_erro     = res_erro;
    assign bus.res_repetido = res_repetido;
    assign bus.led_r        = led_r;
    assign bus.led_g        = led_g;
    assign bus.led_b        = led_b;
`ifdef CONTADOR_TIROS_EN
    assign bus.tiros_total  = tiros_total;
`endif
endmodule

// File: doc/gerenciador_de_jogo_param.md
Name: gerenciador_de_jogo_param

Overview:
Parametrised successor to the fixed 7x5 attack manager. It holds the game FSM (off / preparation / attack / victory / defeat) for an R x C board with a configurable life count. It loads a ship map during preparation and tracks every shot. It reports hit, miss and repeat per shot, and drives the LED-matrix shot/hit planes, lives, status LEDs and end-of-game flags. It sits between the mode/coordinate switches (already debounced into a single-cycle confirm pulse) and the matrix/display drivers.

Parameters:
LINHAS, 7, board rows (1..8)
COLUNAS, 5, board columns (1..8)
VIDAS, 3, initial lives (1..7)
CW, 3, coordinate width; must satisfy 2^CW >= max(LINHAS, COLUNAS)

Ports:
clock_in  in  1  system clock
reset  in  1  asynchronous, active-high reset
modo  in  2  00 off, 01 preparation, 10 attack, 11 reserved (hold)
confirmar  in  1  single-cycle confirm pulse
coord_linha  in  CW  target row
coord_coluna  in  CW  target column
mapa_in  in  LINHAS*COLUNAS  candidate map, bit r*COLUNAS+c = ship
estado  out  3  0 DESLIGADO, 1 PREPARACAO, 2 ATAQUE, 3 VITORIA, 4 DERROTA
tiros_mat  out  LINHAS*COLUNAS  cells already shot
acertos_mat  out  LINHAS*COLUNAS  cells shot that hold a ship
vida  out  3  remaining lives
mapa_ok  out  1  valid non-empty map loaded
res_acerto  out  1  one-cycle pulse: hit
res_erro  out  1  one-cycle pulse: miss
res_repetido  out  1  one-cycle pulse: repeat or out-of-range shot
led_r, led_g, led_b  out  1  status LEDs, registered

Behaviour:
- Reset values: estado=DESLIGADO; mapa register=0; tiros_mat=0; acertos_mat=0; vida=VIDAS; mapa_ok=0; all pulses=0; LEDs=0. A reset asserted mid-game aborts immediately.
- All outputs are registered. The effect of a confirm sampled at edge N is visible after edge N.
- DESLIGADO: modo=01 -> PREPARACAO. Entering DESLIGADO from any state clears tiros_mat, acertos_mat and all pulses, and sets vida=VIDAS. The map register and mapa_ok are retained.
- PREPARACAO:
  - confirmar with popcount(mapa_in) > 0 -> latch the map, store total_navios = popcount, set mapa_ok=1.
  - confirmar with popcount = 0 -> ignored; mapa_ok unchanged.
  - modo=10 with mapa_ok=1 -> ATAQUE. modo=10 with mapa_ok=0 -> stay.
  - modo=00 -> DESLIGADO.
- ATAQUE, on confirmar:
  - Row >= LINHAS or column >= COLUNAS -> res_repetido; no state change.
  - Cell already in tiros_mat -> res_repetido; no life lost.
  - Cell not yet shot and holds a ship -> set the tiros and acertos bits, res_acerto, acertos_cnt += 1.
  - Cell not yet shot and empty -> set the tiros bit, res_erro, vida -= 1.
- End of game: when acertos_cnt reaches total_navios -> VITORIA on the same edge. When vida reaches 0 -> DERROTA on the same edge. The two cannot coincide, since a single shot is either a hit or a miss.
- VITORIA / DERROTA: confirm is ignored and the planes are frozen. Only modo=00 leaves these states (-> DESLIGADO).
- Mode 11: hold the current state in every state.
- In ATAQUE, modo=01 is illegal; the block stays in ATAQUE. modo=00 -> DESLIGADO.
- Status LEDs are latched after each shot: hit = green, miss = red, repeat = blue. VITORIA forces green, DERROTA forces red, DESLIGADO forces all LEDs off.
- acertos_cnt is sized for LINHAS*COLUNAS and never wraps. vida never underflows.

Optional Feature:
CONTADOR_TIROS_EN
- Defined: adds output port tiros_total, 6 bits. It counts accepted (non-repeat, in-range) shots, saturates at 63, and clears on reset or on entering DESLIGADO.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-ATAQUE with vida=1 -> estado=0, vida=3, tiros_mat=0 on the cycle reset asserts.
- PREPARACAO, mapa_in=0, confirmar -> mapa_ok stays 0. Then modo=10 -> estado stays 1.
- Map with ships at (0,0) and (6,4), defaults: confirm, modo=10. Shoot (0,0) -> res_acerto, acertos_mat bit0=1. Shoot (6,4) -> VITORIA, led_g=1.
- Same map: three misses at (1,1), (2,2), (3,3) -> vida 3->2->1->0, estado=DERROTA. A fourth confirm is ignored.
- Repeat shot at (1,1) after a miss -> res_repetido, vida unchanged.
- Shot at row 7 with LINHAS=7 -> res_repetido, tiros_mat unchanged.
- With CONTADOR_TIROS_EN: two accepted shots plus one repeat -> tiros_total=2.
